// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID boundary: owns the PC, drives the synchronous
// instruction SRAM and presents the ID-slot instruction/PC with stall hold and redirect squash.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned IM_ADDR_W = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           pc_sel,
  input  logic [31:0]          redirect_pc,
  output logic                 im_cs,
  output logic [IM_ADDR_W-1:0] im_addr,
  input  logic [31:0]          im_dout,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_instr,
  output logic                 id_valid
);

  localparam logic [1:0] SEL_SEQ   = 2'b00;
  localparam logic [1:0] SEL_REDIR = 2'b01;

  logic [31:0] pc_q;
  logic [31:0] id_pc_q;
  logic        fetch_ok_q;
  logic [31:0] hold_buf;
  logic        hold_valid_q;
  logic [31:0] redirect_aligned;

  // Targets are word-aligned silently; low bits are dropped rather than trapped.
  assign redirect_aligned = redirect_pc & ~32'h0000_0003;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      id_pc_q      <= 32'h0000_0000;
      fetch_ok_q   <= 1'b0;
      hold_buf     <= 32'h0000_0000;
      hold_valid_q <= 1'b0;
    end else begin
      case (pc_sel)
        SEL_SEQ: begin
          pc_q         <= pc_q + 32'd4;
          id_pc_q      <= pc_q;
          fetch_ok_q   <= 1'b1;
          hold_valid_q <= 1'b0;
        end
        SEL_REDIR: begin
          pc_q         <= redirect_aligned;
          fetch_ok_q   <= 1'b0;
          hold_valid_q <= 1'b0;
        end
        default: begin
          // SRAM re-reads pc_q while stalled, so capture the ID word on the first stall edge only.
          if (!hold_valid_q) begin
            hold_buf     <= im_dout;
            hold_valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign im_cs    = ~rst;
  assign im_addr  = pc_q[IM_ADDR_W+1:2];
  assign id_valid = fetch_ok_q;
  assign id_pc    = id_pc_q;

  always_comb begin
    id_instr = NOP_INSTR;
    if (fetch_ok_q) begin
      id_instr = hold_valid_q ? hold_buf : im_dout;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: two instances (reset PC 0 and FFFF_FFFC) sharing a
// behavioural 1-cycle-latency instruction SRAM image.
module tb_if_fetch_stage;

  localparam int unsigned AW = 14;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IA  = 32'hAAAA_0001;
  localparam logic [31:0] IB  = 32'hBBBB_0002;
  localparam logic [31:0] IC  = 32'hCCCC_0003;
  localparam logic [31:0] ID  = 32'hDDDD_0004;
  localparam logic [31:0] ITOP = 32'h1234_5678;

  logic clk;
  logic rst0, rst1;
  logic [1:0] pc_sel0, pc_sel1;
  logic [31:0] redirect0, redirect1;
  logic im_cs0, im_cs1;
  logic [AW-1:0] im_addr0, im_addr1;
  logic [31:0] dout0, dout1;
  logic [31:0] id_pc0, id_pc1, id_instr0, id_instr1;
  logic id_valid0, id_valid1;

  logic [31:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP), .IM_ADDR_W(AW)) dut0 (
    .clk(clk), .rst(rst0), .pc_sel(pc_sel0), .redirect_pc(redirect0),
    .im_cs(im_cs0), .im_addr(im_addr0), .im_dout(dout0),
    .id_pc(id_pc0), .id_instr(id_instr0), .id_valid(id_valid0)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP), .IM_ADDR_W(AW)) dut1 (
    .clk(clk), .rst(rst1), .pc_sel(pc_sel1), .redirect_pc(redirect1),
    .im_cs(im_cs1), .im_addr(im_addr1), .im_dout(dout1),
    .id_pc(id_pc1), .id_instr(id_instr1), .id_valid(id_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (im_cs0) dout0 <= mem[im_addr0];
    if (im_cs1) dout1 <= mem[im_addr1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_id0(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic valid);
    chk({tag, ".id_pc"}, id_pc0, pc);
    chk({tag, ".id_instr"}, id_instr0, instr);
    chk({tag, ".id_valid"}, 32'(id_valid0), 32'(valid));
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    pc_sel0 = 2'b00; pc_sel1 = 2'b00;
    redirect0 = 32'h0; redirect1 = 32'h0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[0] = IA; mem[1] = IB; mem[2] = IC; mem[3] = ID;
    mem[(1 << AW) - 1] = ITOP;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.im_cs", 32'(im_cs0), 32'h0);
    chk("rst.im_addr", 32'(im_addr0), 32'h0);
    chk_id0("rst", 32'h0, NOP, 1'b0);
    #3 rst0 = 1'b0;
    #1;
    chk("rel.im_cs", 32'(im_cs0), 32'h1);
    chk("rel.im_addr", 32'(im_addr0), 32'h0);
    chk_id0("rel", 32'h0, NOP, 1'b0);

    // Sequential: A then B
    tick();
    chk_id0("seqA", 32'h0, IA, 1'b1);
    chk("seqA.im_addr", 32'(im_addr0), 32'h1);
    tick();
    chk_id0("seqB", 32'h4, IB, 1'b1);
    chk("seqB.im_addr", 32'(im_addr0), 32'h2);

    // Stall with pc_sel=10 while B in ID
    pc_sel0 = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_id0("stall10", 32'h4, IB, 1'b1);
      chk("stall10.im_addr", 32'(im_addr0), 32'h2);
    end
    pc_sel0 = 2'b00;
    tick();
    chk_id0("relC", 32'h8, IC, 1'b1);
    chk("relC.im_addr", 32'(im_addr0), 32'h3);

    // Stall with reserved code 11 while C in ID
    pc_sel0 = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_id0("stall11", 32'h8, IC, 1'b1);
    end
    pc_sel0 = 2'b00;
    tick();
    chk_id0("relD", 32'hC, ID, 1'b1);
    chk("relD.im_addr", 32'(im_addr0), 32'h4);

    // Redirect to unaligned 0x103 -> 0x100
    pc_sel0 = 2'b01; redirect0 = 32'h0000_0103;
    tick();
    chk("redir.im_addr", 32'(im_addr0), 32'h40);
    chk_id0("redir.bubble", 32'hC, NOP, 1'b0);
    pc_sel0 = 2'b00; redirect0 = 32'h0;
    tick();
    chk_id0("redir.tgt", 32'h100, 32'hC0DE_0040, 1'b1);
    chk("redir.tgt.im_addr", 32'(im_addr0), 32'h41);
    tick();
    chk_id0("redir.next", 32'h104, 32'hC0DE_0041, 1'b1);

    // Stall 2 cycles then redirect to 0x200; held word must be dropped
    pc_sel0 = 2'b10;
    repeat (2) tick();
    chk_id0("hold2", 32'h104, 32'hC0DE_0041, 1'b1);
    pc_sel0 = 2'b01; redirect0 = 32'h0000_0200;
    tick();
    chk("hredir.im_addr", 32'(im_addr0), 32'h80);
    chk_id0("hredir.bubble", 32'h104, NOP, 1'b0);
    pc_sel0 = 2'b00;
    tick();
    chk_id0("hredir.tgt", 32'h200, 32'hC0DE_0080, 1'b1);

    // Back-to-back redirects 0x10 then 0x20
    pc_sel0 = 2'b01; redirect0 = 32'h0000_0010;
    tick();
    chk("b2b1.im_addr", 32'(im_addr0), 32'h4);
    chk_id0("b2b1", 32'h200, NOP, 1'b0);
    redirect0 = 32'h0000_0020;
    tick();
    chk("b2b2.im_addr", 32'(im_addr0), 32'h8);
    chk_id0("b2b2", 32'h200, NOP, 1'b0);
    pc_sel0 = 2'b00; redirect0 = 32'h0;
    tick();
    chk_id0("b2b.tgt", 32'h20, 32'hC0DE_0008, 1'b1);

    // Asynchronous reset mid-stall
    pc_sel0 = 2'b10;
    repeat (2) tick();
    chk_id0("prerst", 32'h20, 32'hC0DE_0008, 1'b1);
    #2 rst0 = 1'b1;
    #1;
    chk_id0("arst", 32'h0, NOP, 1'b0);
    chk("arst.im_cs", 32'(im_cs0), 32'h0);
    chk("arst.im_addr", 32'(im_addr0), 32'h0);
    #2 rst0 = 1'b0;
    pc_sel0 = 2'b00;
    #1;
    chk_id0("arst.rel", 32'h0, NOP, 1'b0);
    tick();
    chk_id0("arst.A", 32'h0, IA, 1'b1);

    // PC wrap from FFFF_FFFC on the second instance
    chk("wrap.rst.im_addr", 32'(im_addr1), 32'h3FFF);
    chk("wrap.rst.valid", 32'(id_valid1), 32'h0);
    #2 rst1 = 1'b0;
    tick();
    chk("wrap.top.id_pc", id_pc1, 32'hFFFF_FFFC);
    chk("wrap.top.id_instr", id_instr1, ITOP);
    chk("wrap.top.im_addr", 32'(im_addr1), 32'h0);
    tick();
    chk("wrap.zero.id_pc", id_pc1, 32'h0);
    chk("wrap.zero.id_instr", id_instr1, IA);
    chk("wrap.zero.valid", 32'(id_valid1), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
